// File: rtl/if_stage_pipe_if.sv
// ----------------------------------------------------------------------------
// if_stage_pipe_if
// Purpose : Groups the control, redirect, instruction-memory and IF/ID signals
//           of the instruction-fetch stage into one bundle.
// Signals :
//   PCWrite, IF_ID_Write        hazard-unit freeze controls
//   branch_taken/branch_target  EX/MEM-resolved branch redirect
//   jump/jump_target            ID-resolved jump redirect
//   imem_addr/imem_rdata        instruction-memory address and read data
//   pc                          current program counter
//   IF_ID_PC4/Instr/Valid       IF/ID pipeline register contents
// Modports:
//   master : the surrounding pipeline (drives controls, imem data)
//   slave  : the fetch stage itself
// ----------------------------------------------------------------------------
interface if_stage_pipe_if;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] IF_ID_PC4;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_Valid;

    modport master (
        output PCWrite, IF_ID_Write, branch_taken, branch_target,
               jump, jump_target, imem_rdata,
        input  imem_addr, pc, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid
    );

    modport slave (
        input  PCWrite, IF_ID_Write, branch_taken, branch_target,
               jump, jump_target, imem_rdata,
        output imem_addr, pc, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid
    );
endinterface

// File: rtl/if_stage_pipe.sv
// ----------------------------------------------------------------------------
// if_stage_pipe
// Purpose : Instruction-fetch stage plus IF/ID pipeline register of a 5-stage
//           MIPS pipeline. Holds the PC, presents it to instruction memory,
//           selects the next PC (sequential / jump / branch) and latches the
//           fetched word into IF/ID, honouring hazard-unit freezes and
//           squashing IF/ID on redirects.
// Ports   :
//   clk    pipeline clock, rising edge
//   reset  synchronous, active-high reset (highest priority)
//   bus    if_stage_pipe_if.slave - controls, redirects, imem, IF/ID outputs
// ----------------------------------------------------------------------------
module if_stage_pipe #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    if_stage_pipe_if.slave bus
);

    logic [31:0] r_pc;
    logic [31:0] r_if_id_pc4;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;

    // Natural 32-bit wrap gives 0xFFFF_FFFC + 4 = 0.
    assign w_pc_plus4      = r_pc + 32'd4;

    // Redirect targets are forced onto a word boundary.
    assign w_branch_target = {bus.branch_target[31:2], 2'b00};
    assign w_jump_target   = {bus.jump_target[31:2], 2'b00};

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values of its neighbours, e.g. IF/ID captures the old pc+4.
        if (reset) begin
            r_pc          <= RESET_PC;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc4   <= 32'd0;
            r_if_id_valid <= 1'b0;
        end else if (bus.branch_taken) begin
            // Branch is older than anything in IF/ID, so it wins over stalls
            // and over a jump that is itself about to be squashed.
            r_pc          <= w_branch_target;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc4   <= 32'd0;
            r_if_id_valid <= 1'b0;
        end else if (bus.jump && bus.PCWrite) begin
            // A jump during a stall is ignored; ID re-presents it afterwards.
            r_pc          <= w_jump_target;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc4   <= 32'd0;
            r_if_id_valid <= 1'b0;
        end else begin
            // PC and IF/ID freezes are independent of each other.
            if (bus.PCWrite) begin
                r_pc <= w_pc_plus4;
            end
            if (bus.IF_ID_Write) begin
                r_if_id_instr <= bus.imem_rdata;
                r_if_id_pc4   <= w_pc_plus4;
                r_if_id_valid <= 1'b1;
            end
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.pc          = r_pc;
    assign bus.IF_ID_PC4   = r_if_id_pc4;
    assign bus.IF_ID_Instr = r_if_id_instr;
    assign bus.IF_ID_Valid = r_if_id_valid;

endmodule

// File: tb/tb_if_stage_pipe.sv
// ----------------------------------------------------------------------------
// tb_if_stage_pipe
// Purpose : Directed self-checking bench for if_stage_pipe. Instruction memory
//           is modelled as word = addr | 0xA000_0000; all expected values are
//           hand-computed constants.
// ----------------------------------------------------------------------------
module tb_if_stage_pipe;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    if_stage_pipe_if bus ();

    if_stage_pipe #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Combinational instruction memory.
    assign bus.imem_rdata = bus.imem_addr | 32'hA000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc,
                           input logic [31:0] e_instr, input logic [31:0] e_pc4,
                           input logic e_valid);
        chk({tag, ".pc"},    bus.pc,          e_pc);
        chk({tag, ".addr"},  bus.imem_addr,   e_pc);
        chk({tag, ".instr"}, bus.IF_ID_Instr, e_instr);
        chk({tag, ".pc4"},   bus.IF_ID_PC4,   e_pc4);
        chk({tag, ".valid"}, {31'd0, bus.IF_ID_Valid}, {31'd0, e_valid});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset             = 1'b1;
        bus.PCWrite       = 1'b1;
        bus.IF_ID_Write   = 1'b1;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'd0;
        bus.jump          = 1'b0;
        bus.jump_target   = 32'd0;

        // Reset state.
        step();
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;

        // Free run: first fetch from 0.
        step();
        chk_all("run1", 32'h4, 32'hA000_0000, 32'h4, 1'b1);
        step();
        step();
        step();
        chk_all("run4", 32'h10, 32'hA000_000C, 32'h10, 1'b1);

        // Two-cycle load-use stall at pc=0x10.
        bus.PCWrite     = 1'b0;
        bus.IF_ID_Write = 1'b0;
        step();
        chk_all("stall1", 32'h10, 32'hA000_000C, 32'h10, 1'b1);
        step();
        chk_all("stall2", 32'h10, 32'hA000_000C, 32'h10, 1'b1);
        bus.PCWrite     = 1'b1;
        bus.IF_ID_Write = 1'b1;
        step();
        chk_all("resume", 32'h14, 32'hA000_0010, 32'h14, 1'b1);

        // Branch overrides a stall.
        bus.PCWrite       = 1'b0;
        bus.IF_ID_Write   = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h40;
        step();
        chk_all("br_stall", 32'h40, 32'h0, 32'h0, 1'b0);
        bus.branch_taken = 1'b0;
        bus.PCWrite      = 1'b1;
        bus.IF_ID_Write  = 1'b1;
        step();
        chk_all("br_fetch", 32'h44, 32'hA000_0040, 32'h44, 1'b1);

        // Jump to unaligned target, aligned to 0x100, bubble inserted.
        bus.jump        = 1'b1;
        bus.jump_target = 32'h103;
        step();
        chk("jmp.pc", bus.pc, 32'h100);
        chk("jmp.instr", bus.IF_ID_Instr, 32'h0);
        chk("jmp.valid", {31'd0, bus.IF_ID_Valid}, 32'd0);
        // Same jump during a stall is ignored.
        bus.PCWrite     = 1'b0;
        bus.IF_ID_Write = 1'b0;
        step();
        chk("jmp_stall.pc", bus.pc, 32'h100);
        chk("jmp_stall.valid", {31'd0, bus.IF_ID_Valid}, 32'd0);
        bus.jump        = 1'b0;
        bus.PCWrite     = 1'b1;
        bus.IF_ID_Write = 1'b1;
        step();
        chk_all("jmp_fetch", 32'h104, 32'hA000_0100, 32'h104, 1'b1);

        // Branch beats a simultaneous jump.
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h80;
        bus.jump          = 1'b1;
        bus.jump_target   = 32'h200;
        step();
        chk_all("br_vs_jmp", 32'h80, 32'h0, 32'h0, 1'b0);
        bus.jump = 1'b0;

        // Back-to-back branches keep IF/ID empty.
        bus.branch_target = 32'h300;
        step();
        chk_all("b2b_1", 32'h300, 32'h0, 32'h0, 1'b0);
        bus.branch_target = 32'h400;
        step();
        chk_all("b2b_2", 32'h400, 32'h0, 32'h0, 1'b0);
        bus.branch_taken = 1'b0;

        // PC wrap: jump to the last word, then advance.
        bus.jump        = 1'b1;
        bus.jump_target = 32'hFFFF_FFFC;
        step();
        chk("wrap0.pc", bus.pc, 32'hFFFF_FFFC);
        bus.jump = 1'b0;
        step();
        chk_all("wrap1", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);

        // PCWrite without IF_ID_Write: pc moves, IF/ID holds.
        bus.IF_ID_Write = 1'b0;
        step();
        chk_all("pc_only", 32'h4, 32'hFFFF_FFFC, 32'h0, 1'b1);
        bus.IF_ID_Write = 1'b1;
        step();
        chk_all("run_again", 32'h8, 32'hA000_0004, 32'h8, 1'b1);

        // Reset during a stall with a pending branch.
        bus.PCWrite       = 1'b0;
        bus.IF_ID_Write   = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h500;
        reset             = 1'b1;
        step();
        chk_all("rst_stall", 32'h0, 32'h0, 32'h0, 1'b0);
        reset            = 1'b0;
        bus.branch_taken = 1'b0;
        bus.PCWrite      = 1'b1;
        bus.IF_ID_Write  = 1'b1;
        step();
        chk_all("post_rst", 32'h4, 32'hA000_0000, 32'h4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage_pipe.md
Name: if_stage_pipe

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline.
- Holds the PC and drives the instruction-memory address.
- Selects the next PC from sequential, jump (ID-resolved) and branch (EX/MEM-resolved) sources.
- Latches the fetched word into IF/ID. Obeys the PCWrite/IF_ID_Write freeze from the hazard detection unit and flushes on redirects.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, encoding inserted into IF/ID on flush/reset (sll $0,$0,0).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- PCWrite  input  1  1 = PC may update; 0 = hold PC (load-use stall).
- IF_ID_Write  input  1  1 = IF/ID may load; 0 = hold IF/ID contents.
- branch_taken  input  1  taken branch resolved downstream; redirect and flush.
- branch_target  input  32  branch destination address.
- jump  input  1  J/JAL/JR decoded in ID; redirect and flush IF.
- jump_target  input  32  jump destination address.
- imem_addr  output  32  instruction-memory address (= pc, combinational).
- imem_rdata  input  32  instruction word, combinational read of imem_addr.
- pc  output  32  current PC register.
- IF_ID_PC4  output  32  registered PC+4 of the instruction in ID.
- IF_ID_Instr  output  32  registered instruction in ID.
- IF_ID_Valid  output  1  1 = IF_ID_Instr is a real instruction; 0 = bubble.

Behaviour:
- All state updates occur on the rising edge of clk. There is no asynchronous path. imem_addr = pc combinationally.
- Reset (reset=1 at edge) has top priority over all other inputs. Resulting values:
  - pc = RESET_PC
  - IF_ID_Instr = NOP_INSTR
  - IF_ID_PC4 = 0
  - IF_ID_Valid = 0
- Reset asserted mid-stall or mid-redirect discards both; the first fetch after deassert is at RESET_PC.
- Fetch latency is 1 cycle: the word at pc appears on IF_ID_Instr after the next edge.
- Targets are word-aligned internally: bits [1:0] of branch_target/jump_target are forced to 0. pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Per-edge priority, highest first:
  1. reset: as above.
  2. branch_taken=1: pc <= branch_target; IF_ID_Instr <= NOP_INSTR; IF_ID_Valid <= 0; IF_ID_PC4 <= 0.
     - Overrides PCWrite=0, IF_ID_Write=0 and jump. The stalled or jumping instruction is younger than the branch and is squashed.
  3. jump=1 and PCWrite=1: pc <= jump_target; IF/ID loaded with bubble (NOP_INSTR, Valid=0).
     - jump while PCWrite=0 is ignored. The jump in ID is held and re-presented after the stall.
  4. PCWrite=1: pc <= pc+4. Otherwise pc holds.
  5. IF_ID_Write=1: IF_ID_Instr <= imem_rdata; IF_ID_PC4 <= pc+4; IF_ID_Valid <= 1. Otherwise all IF/ID fields hold.
- PCWrite and IF_ID_Write are evaluated independently. PCWrite=1 with IF_ID_Write=0 advances pc without capture; this is legal but the hazard unit never produces it.
- A stall of N consecutive cycles holds pc and IF/ID unchanged for N edges. Normal advance resumes on the first edge with PCWrite=1.
- Back-to-back branch_taken on consecutive edges: each redirect takes effect and IF_ID_Valid stays 0 throughout.

Test Plan:
- Reset then free-run, imem returns word = addr|0xA000_0000 -> pc 0,4,8,...; after the 1st edge IF_ID_Instr=0xA000_0000, IF_ID_PC4=4, Valid=1.
- Load-use stall: PCWrite=IF_ID_Write=0 for 2 cycles at pc=0x10 -> pc and IF/ID (Instr@0xC, PC4=0x10) held for 2 edges, then pc=0x14.
- branch_taken with target 0x40 while PCWrite=0 -> pc=0x40, IF_ID_Valid=0, IF_ID_Instr=NOP_INSTR next edge; fetch from 0x40 follows.
- jump target 0x103 with PCWrite=1 -> pc=0x100, bubble in IF/ID. The same jump with PCWrite=0 -> pc unchanged.
- Simultaneous branch_taken (0x80) and jump (0x200) -> pc=0x80.
- Wrap: force pc to 0xFFFF_FFFC -> next pc=0, IF_ID_PC4=0. reset asserted during a stall -> pc=RESET_PC, Valid=0.
